// File: rtl/issue_pkg.sv
// Shared types and constants for the dual-issue scheduler.
//   issue_state_t : scheduler FSM state (NORMAL / WAIT_DS)
//   slot_info_t   : register fields and write-back flag of one FIFO slot
//   REG_ZERO      : architectural $zero, never a real dependency
//   reads_reg     : true when a slot sources a given nonzero register
package issue_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [0:0] {
    NORMAL  = 1'b0,
    WAIT_DS = 1'b1
  } issue_state_t;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] dest;
    logic       wb_en;
  } slot_info_t;

  function automatic logic reads_reg(input slot_info_t s, input logic [4:0] r);
    return (r != REG_ZERO) && ((s.rs == r) || (s.rt == r));
  endfunction

endpackage

// File: rtl/issue_hazard_check.sv
// Pure combinational hazard checker for the two oldest FIFO slots.
//   slot_a, slot_b : register fields of slot A (older) and slot B
//   ld_valid/dest  : last issued load still in flight
//   a_lu_dep       : slot A reads the in-flight load result
//   b_lu_dep       : slot B reads the in-flight load result
//   raw_ab         : slot B reads what slot A writes
//   waw_ab         : both slots write the same register
module issue_hazard_check
  import issue_pkg::*;
(
  input  slot_info_t slot_a,
  input  slot_info_t slot_b,
  input  logic       ld_valid,
  input  logic [4:0] ld_dest,
  output logic       a_lu_dep,
  output logic       b_lu_dep,
  output logic       raw_ab,
  output logic       waw_ab
);

  // Dependency evaluation; reads_reg already excludes $zero
  always_comb begin
    a_lu_dep = ld_valid && reads_reg(slot_a, ld_dest);
    b_lu_dep = ld_valid && reads_reg(slot_b, ld_dest);
    raw_ab   = slot_a.wb_en && reads_reg(slot_b, slot_a.dest);
    waw_ab   = slot_a.wb_en && slot_b.wb_en && (slot_a.dest == slot_b.dest);
  end

endmodule

// File: rtl/dual_issue_ctrl.sv
// Dual-issue scheduler: picks 0, 1 (master) or 2 (master+slave) instructions
// per cycle from the IF FIFO, drives stage enables, tracks branch delay slots
// and load-use bubbles, and keeps issue statistics.
//   clk, rst (sync, active-high), flush : clock, reset, pipeline flush
//   fifo_count                          : visible FIFO entries (0..2)
//   a_* / b_*                           : decode info of slot A / slot B
//   mem_busy, div_busy                  : back-end stalls
//   issue_a, issue_b, fifo_pop          : issue decision (combinational)
//   en_id_ex, en_ex_mem, en_mem_wb      : stage enables (combinational)
//   redirect_hold                       : branch issued, delay slot pending
//   cnt_dual, cnt_single, cnt_stall     : wrapping performance counters
module dual_issue_ctrl
  import issue_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [1:0]       fifo_count,
  input  logic [4:0]       a_rs,
  input  logic [4:0]       a_rt,
  input  logic [4:0]       a_dest,
  input  logic             a_wb_en,
  input  logic             a_is_branch,
  input  logic             a_is_load,
  input  logic             a_is_solo,
  input  logic [4:0]       b_rs,
  input  logic [4:0]       b_rt,
  input  logic [4:0]       b_dest,
  input  logic             b_wb_en,
  input  logic             b_is_simple,
  input  logic             b_is_branch,
  input  logic             b_is_load,
  input  logic             mem_busy,
  input  logic             div_busy,
  output logic             issue_a,
  output logic             issue_b,
  output logic [1:0]       fifo_pop,
  output logic             en_id_ex,
  output logic             en_ex_mem,
  output logic             en_mem_wb,
  output logic             redirect_hold,
  output logic [CNT_W-1:0] cnt_dual,
  output logic [CNT_W-1:0] cnt_single,
  output logic [CNT_W-1:0] cnt_stall
);

  issue_state_t     state_q, state_d;
  logic             ld_valid_q, ld_valid_d;
  logic [4:0]       ld_dest_q, ld_dest_d;
  logic [CNT_W-1:0] cnt_dual_q, cnt_dual_d;
  logic [CNT_W-1:0] cnt_single_q, cnt_single_d;
  logic [CNT_W-1:0] cnt_stall_q, cnt_stall_d;

  slot_info_t slot_a_s, slot_b_s;
  logic       a_lu_dep_s, b_lu_dep_s, raw_ab_s, waw_ab_s;
  logic       lu_stall_s, dual_ok_s;

  assign slot_a_s = '{rs: a_rs, rt: a_rt, dest: a_dest, wb_en: a_wb_en};
  assign slot_b_s = '{rs: b_rs, rt: b_rt, dest: b_dest, wb_en: b_wb_en};

  issue_hazard_check u_hazard (
    .slot_a   (slot_a_s),
    .slot_b   (slot_b_s),
    .ld_valid (ld_valid_q),
    .ld_dest  (ld_dest_q),
    .a_lu_dep (a_lu_dep_s),
    .b_lu_dep (b_lu_dep_s),
    .raw_ab   (raw_ab_s),
    .waw_ab   (waw_ab_s)
  );

  // Stage enables and issue decision; everything is forced low during reset
  always_comb begin
    en_mem_wb  = !rst && !mem_busy;
    en_ex_mem  = !rst && !mem_busy && !div_busy;
    lu_stall_s = !rst && (fifo_count != 2'd0) && a_lu_dep_s;
    en_id_ex   = en_ex_mem && !lu_stall_s;
    dual_ok_s  = (fifo_count >= 2'd2) && b_is_simple && !b_is_branch && !b_is_load
                 && !a_is_solo && !raw_ab_s && !waw_ab_s && !b_lu_dep_s;
    issue_a    = en_id_ex && !flush && (fifo_count != 2'd0);
    // The delay slot waiting in WAIT_DS always goes alone
    issue_b    = issue_a && (state_q == NORMAL) && dual_ok_s;
    fifo_pop   = {1'b0, issue_a} + {1'b0, issue_b};
    if (rst) begin
      redirect_hold = 1'b0;
    end else begin
      case (state_q)
        NORMAL:  redirect_hold = issue_a && !issue_b && a_is_branch;
        WAIT_DS: redirect_hold = !issue_a;
        default: redirect_hold = 1'b0;
      endcase
    end
  end

  // Next-state for FSM, load tracker and counters
  always_comb begin
    state_d      = state_q;
    ld_valid_d   = ld_valid_q;
    ld_dest_d    = ld_dest_q;
    cnt_dual_d   = cnt_dual_q;
    cnt_single_d = cnt_single_q;
    cnt_stall_d  = cnt_stall_q;
    if (flush) begin
      state_d    = NORMAL;
      ld_valid_d = 1'b0;
    end else if (en_ex_mem && lu_stall_s) begin
      // The bubble lets the load reach MEM, so the dependency is resolved
      ld_valid_d  = 1'b0;
      cnt_stall_d = cnt_stall_q + CNT_W'(1);
    end else if (en_id_ex) begin
      if (issue_a) begin
        case (state_q)
          NORMAL:  state_d = (a_is_branch && !issue_b) ? WAIT_DS : NORMAL;
          WAIT_DS: state_d = NORMAL;
          default: state_d = NORMAL;
        endcase
        // Slot B is never a load, so only slot A can start a new load-use window
        ld_valid_d = a_is_load && a_wb_en && (a_dest != REG_ZERO);
        ld_dest_d  = a_dest;
        if (issue_b) begin
          cnt_dual_d = cnt_dual_q + CNT_W'(1);
        end else begin
          cnt_single_d = cnt_single_q + CNT_W'(1);
        end
      end else begin
        // Enabled cycle with an empty FIFO
        cnt_stall_d = cnt_stall_q + CNT_W'(1);
      end
    end else begin
      state_d = state_q;
    end
  end

  // State and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= NORMAL;
      ld_valid_q   <= 1'b0;
      ld_dest_q    <= REG_ZERO;
      cnt_dual_q   <= '0;
      cnt_single_q <= '0;
      cnt_stall_q  <= '0;
    end else begin
      state_q      <= state_d;
      ld_valid_q   <= ld_valid_d;
      ld_dest_q    <= ld_dest_d;
      cnt_dual_q   <= cnt_dual_d;
      cnt_single_q <= cnt_single_d;
      cnt_stall_q  <= cnt_stall_d;
    end
  end

  assign cnt_dual   = cnt_dual_q;
  assign cnt_single = cnt_single_q;
  assign cnt_stall  = cnt_stall_q;

endmodule

// File: tb/tb_dual_issue_ctrl.sv
module tb_dual_issue_ctrl;

  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst, flush, mem_busy, div_busy;
  logic [1:0] fifo_count;
  logic [4:0] a_rs, a_rt, a_dest, b_rs, b_rt, b_dest;
  logic a_wb_en, a_is_branch, a_is_load, a_is_solo;
  logic b_wb_en, b_is_simple, b_is_branch, b_is_load;
  logic issue_a, issue_b, en_id_ex, en_ex_mem, en_mem_wb, redirect_hold;
  logic [1:0] fifo_pop;
  logic [CW-1:0] cnt_dual, cnt_single, cnt_stall;

  int errors = 0;
  int checks = 0;

  // reference model state
  bit m_wait = 1'b0;
  bit m_ldv = 1'b0;
  logic [4:0] m_ldd = 5'd0;
  logic [CW-1:0] m_dual = '0, m_single = '0, m_stall = '0;

  always #5 clk = ~clk;

  dual_issue_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .fifo_count(fifo_count),
    .a_rs(a_rs), .a_rt(a_rt), .a_dest(a_dest), .a_wb_en(a_wb_en),
    .a_is_branch(a_is_branch), .a_is_load(a_is_load), .a_is_solo(a_is_solo),
    .b_rs(b_rs), .b_rt(b_rt), .b_dest(b_dest), .b_wb_en(b_wb_en),
    .b_is_simple(b_is_simple), .b_is_branch(b_is_branch), .b_is_load(b_is_load),
    .mem_busy(mem_busy), .div_busy(div_busy),
    .issue_a(issue_a), .issue_b(issue_b), .fifo_pop(fifo_pop),
    .en_id_ex(en_id_ex), .en_ex_mem(en_ex_mem), .en_mem_wb(en_mem_wb),
    .redirect_hold(redirect_hold),
    .cnt_dual(cnt_dual), .cnt_single(cnt_single), .cnt_stall(cnt_stall)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_a(input int rs, input int rt, input int dest, input bit wb,
                       input bit br, input bit ld, input bit solo);
    a_rs = 5'(rs); a_rt = 5'(rt); a_dest = 5'(dest); a_wb_en = wb;
    a_is_branch = br; a_is_load = ld; a_is_solo = solo;
  endtask

  task automatic set_b(input int rs, input int rt, input int dest, input bit wb,
                       input bit simple, input bit br, input bit ld);
    b_rs = 5'(rs); b_rt = 5'(rt); b_dest = 5'(dest); b_wb_en = wb;
    b_is_simple = simple; b_is_branch = br; b_is_load = ld;
  endtask

  function automatic bit reads(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] r);
    return (r != 5'd0) && (rs == r || rt == r);
  endfunction

  // Check one cycle against the model (inputs already set at negedge), then clock it.
  task automatic step(input string tag);
    bit e_mwb, e_exm, e_idex, stall, pair_ok, e_hold;
    int n;
    #2;
    e_mwb = !rst && !mem_busy;
    e_exm = !rst && !mem_busy && !div_busy;
    stall = !rst && fifo_count > 0 && m_ldv && reads(a_rs, a_rt, m_ldd);
    e_idex = e_exm && !stall;
    pair_ok = !m_wait && fifo_count >= 2 && b_is_simple && !b_is_branch && !b_is_load
              && !a_is_solo
              && !(a_wb_en && reads(b_rs, b_rt, a_dest))
              && !(a_wb_en && b_wb_en && a_dest == b_dest)
              && !(m_ldv && reads(b_rs, b_rt, m_ldd));
    n = (e_idex && !flush && fifo_count > 0) ? (pair_ok ? 2 : 1) : 0;
    e_hold = !rst && (m_wait ? (n == 0) : (n == 1 && a_is_branch));
    check({tag, ".issue_a"}, 32'(issue_a), 32'(n >= 1));
    check({tag, ".issue_b"}, 32'(issue_b), 32'(n == 2));
    check({tag, ".fifo_pop"}, 32'(fifo_pop), 32'(n));
    check({tag, ".en_mem_wb"}, 32'(en_mem_wb), 32'(e_mwb));
    check({tag, ".en_ex_mem"}, 32'(en_ex_mem), 32'(e_exm));
    check({tag, ".en_id_ex"}, 32'(en_id_ex), 32'(e_idex));
    check({tag, ".redirect_hold"}, 32'(redirect_hold), 32'(e_hold));
    check({tag, ".cnt_dual"}, 32'(cnt_dual), 32'(m_dual));
    check({tag, ".cnt_single"}, 32'(cnt_single), 32'(m_single));
    check({tag, ".cnt_stall"}, 32'(cnt_stall), 32'(m_stall));
    @(posedge clk);
    if (rst) begin
      m_wait = 0; m_ldv = 0; m_dual = '0; m_single = '0; m_stall = '0;
    end else if (flush) begin
      m_wait = 0; m_ldv = 0;
    end else if (e_exm && stall) begin
      m_ldv = 0; m_stall++;
    end else if (e_idex) begin
      if (n == 0) m_stall++;
      else begin
        if (n == 2) m_dual++; else m_single++;
        m_wait = m_wait ? 1'b0 : (n == 1 && a_is_branch);
        m_ldv = a_is_load && a_wb_en && a_dest != 5'd0;
        m_ldd = a_dest;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    flush = 0; mem_busy = 0; div_busy = 0; fifo_count = 2'd0;
    set_a(0, 0, 0, 0, 0, 0, 0);
    set_b(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1; idle();
    @(negedge clk);
    step("reset0");
    step("reset1");
    rst = 0;

    // addu $3,$1,$2 ; or $5,$4,$4
    fifo_count = 2'd2; set_a(1, 2, 3, 1, 0, 0, 0); set_b(4, 4, 5, 1, 1, 0, 0);
    step("dual");
    check("dual_count", 32'(cnt_dual), 32'd1);

    // RAW: B reads $3, then B moves into slot A
    set_b(3, 0, 6, 1, 1, 0, 0);
    step("raw");
    fifo_count = 2'd1; set_a(3, 0, 6, 1, 0, 0, 0);
    step("raw_next");

    // lw $7 then a consumer of $7
    set_a(1, 0, 7, 1, 0, 1, 0);
    step("load");
    set_a(7, 0, 8, 1, 0, 0, 0);
    step("load_use");
    check("stall_count", 32'(cnt_stall), 32'd1);
    step("after_stall");

    // branch alone, then its delay slot
    set_a(1, 2, 0, 0, 1, 0, 0);
    step("branch");
    set_a(2, 3, 4, 1, 1, 0, 0);
    step("delay_slot");

    // divider busy for five cycles with a dual-issuable pair
    fifo_count = 2'd2; set_a(1, 2, 3, 1, 0, 0, 0); set_b(4, 4, 5, 1, 1, 0, 0);
    div_busy = 1;
    for (int i = 0; i < 5; i++) step("div_busy");
    div_busy = 0;

    // flush while waiting for a delay slot, with and without mem_busy
    fifo_count = 2'd1; set_a(1, 2, 0, 0, 1, 0, 0);
    step("branch2");
    mem_busy = 1;
    step("ds_mem_busy");
    flush = 1;
    step("flush_mem_busy");
    flush = 0; mem_busy = 0; fifo_count = 2'd0;
    step("after_flush");
    check("no_hold_after_flush", 32'(redirect_hold), 32'd0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      flush = ($urandom_range(0, 19) == 0);
      mem_busy = ($urandom_range(0, 7) == 0);
      div_busy = ($urandom_range(0, 7) == 0);
      fifo_count = 2'($urandom_range(0, 2));
      set_a($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
      set_b($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
